// File: rtl/uart_rx_fsm_ext_pkg.sv
// uart_pkg -- shared encodings and helpers for the oversampling UART receiver.
// Revision: 1.0
`default_nettype none

package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fsm_ext_if.sv
// uart_rx_fsm_ext_if -- serial input, tick, read handshake and frame status bundle.
// Revision: 1.0
`default_nettype none

interface uart_rx_fsm_ext_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [1:0]      par_mode;
  logic            rd_en;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            rx_valid;
  logic            par_err;
  logic            frame_err;
  logic            brk;
  logic            overrun;

  modport master (
    output rx, s_tick, par_mode, rd_en,
    input  dout, rx_done_tick, rx_valid, par_err, frame_err, brk, overrun
  );

  modport slave (
    input  rx, s_tick, par_mode, rd_en,
    output dout, rx_done_tick, rx_valid, par_err, frame_err, brk, overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fsm_ext_sync.sv
// uart_rx_sync -- two-flop synchroniser that resets to 1 (idle line level).
// Revision: 1.0
`default_nettype none

module uart_rx_sync (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d_i,
  output logic      q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm_ext.sv
// uart_rx_fsm_ext -- oversampling UART receiver with parity, majority voting and read handshake.
// Revision: 1.0
`default_nettype none

module uart_rx_fsm_ext
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  uart_rx_fsm_ext_if.slave  bus
);
  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = clog2(SMAX);
  localparam int NW   = (clog2(DBIT) < 1) ? 1 : clog2(DBIT);

  localparam logic [SW-1:0] C_S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] C_S_V0   = SW'(OVS - 3);
  localparam logic [SW-1:0] C_S_V1   = SW'(OVS - 2);
  localparam logic [SW-1:0] C_S_DEC  = SW'(OVS - 1);
  localparam logic [SW-1:0] C_S_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] C_N_LAST = NW'(DBIT - 1);

  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      pm_q, pm_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic            pbit_q, pbit_d, perr_q, perr_d, stop_q, stop_d;

  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d, valid_q, valid_d, ovr_q, ovr_d;
  logic            pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;

  logic rx_s;
  logic w_bit;
  logic w_stop;
  logic w_complete;
  logic w_rd;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  assign w_bit  = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
  // With SB_TICK == OVS the stop decision and frame completion share one tick.
  assign w_stop = (s_q == C_S_DEC) ? w_bit : stop_q;
  assign w_rd   = bus.rd_en & valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      pm_q    <= PAR_NONE;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      stop_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      pm_q    <= pm_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    pm_d       = pm_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    pbit_d     = pbit_q;
    perr_d     = perr_q;
    stop_d     = stop_q;
    w_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          s_d     = '0;
          pm_d    = bus.par_mode;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (bus.s_tick) begin
          if (s_q == C_S_HALF) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (bus.s_tick) begin
          s_d = s_q + 1'b1;
          if (s_q == C_S_V0) v0_d = rx_s;
          if (s_q == C_S_V1) v1_d = rx_s;
          if (state_q == S_DATA && s_q == C_S_DEC) begin
            s_d = '0;
            b_d = {w_bit, b_q[DBIT-1:1]};
            if (n_q == C_N_LAST)
              state_d = (pm_q == PAR_EVEN || pm_q == PAR_ODD) ? S_PARITY : S_STOP;
            else
              n_d = n_q + 1'b1;
          end
          if (state_q == S_PARITY && s_q == C_S_DEC) begin
            s_d     = '0;
            pbit_d  = w_bit;
            perr_d  = w_bit ^ (^b_q) ^ (pm_q == PAR_ODD);
            state_d = S_STOP;
          end
          if (state_q == S_STOP) begin
            if (s_q == C_S_DEC) stop_d = w_bit;
            if (s_q == C_S_END) begin
              w_complete = 1'b1;
              s_d        = '0;
              state_d    = w_stop ? S_IDLE : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d  = w_complete;
    dout_d  = dout_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (w_complete) begin
      dout_d = b_q;
      pe_d   = perr_q;
      fe_d   = ~w_stop;
      brk_d  = ~w_stop & (b_q == '0) & ~pbit_q;
    end
    // A completion racing a read leaves valid set without flagging overrun.
    if (w_complete)
      valid_d = 1'b1;
    else if (w_rd)
      valid_d = 1'b0;
    if (w_complete && valid_q && !bus.rd_en)
      ovr_d = 1'b1;
    else if (w_rd)
      ovr_d = 1'b0;
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.rx_valid     = valid_q;
  assign bus.par_err      = pe_q;
  assign bus.frame_err    = fe_q;
  assign bus.brk          = brk_q;
  assign bus.overrun      = ovr_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm_ext.sv
// tb_uart_rx_fsm_ext -- scoreboard bench for the oversampling UART receiver.
// Revision: 1.0
`default_nettype none

module tb_uart_rx_fsm_ext;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_fsm_ext_if #(.DBIT(8)) bus ();

  uart_rx_fsm_ext #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic pe, fe, bk, ov;
  } frm_t;

  typedef struct {
    int id;
    logic [7:0] d;
    logic v, pe, fe, bk, ov;
    int ndone;
  } st_t;

  frm_t exp_q[$];
  st_t  st_q[$];
  int npass  = 0;
  int ntot   = 0;
  int n_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pops a frame expectation per rx_done_tick, and state snapshots as queued.
  always @(negedge clk) begin
    frm_t f;
    st_t  s;
    if (bus.rx_done_tick === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        f = exp_q.pop_front();
        chk("frame_dout",    int'(bus.dout),      int'(f.d));
        chk("frame_par_err", int'(bus.par_err),   int'(f.pe));
        chk("frame_fe",      int'(bus.frame_err), int'(f.fe));
        chk("frame_brk",     int'(bus.brk),       int'(f.bk));
        chk("frame_valid",   int'(bus.rx_valid),  1);
        chk("frame_overrun", int'(bus.overrun),   int'(f.ov));
      end
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk($sformatf("st%0d_dout", s.id),    int'(bus.dout),      int'(s.d));
      chk($sformatf("st%0d_valid", s.id),   int'(bus.rx_valid),  int'(s.v));
      chk($sformatf("st%0d_par_err", s.id), int'(bus.par_err),   int'(s.pe));
      chk($sformatf("st%0d_fe", s.id),      int'(bus.frame_err), int'(s.fe));
      chk($sformatf("st%0d_brk", s.id),     int'(bus.brk),       int'(s.bk));
      chk($sformatf("st%0d_overrun", s.id), int'(bus.overrun),   int'(s.ov));
      chk($sformatf("st%0d_ndone", s.id),   n_done,              s.ndone);
      chk($sformatf("st%0d_pending", s.id), exp_q.size(),        0);
    end
  end

  task automatic tick(input logic lvl);
    @(negedge clk);
    bus.rx     = lvl;
    bus.s_tick = 1'b1;
    @(negedge clk);
    bus.s_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bitp(input logic lvl, input bit glitch);
    for (int t = 0; t < 16; t++) tick((glitch && t == 6) ? ~lvl : lvl);
  endtask

  task automatic send(input logic [7:0] d, input bit par, input logic pbit, input int gbit);
    bitp(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bitp(d[i], i == gbit);
    if (par) bitp(pbit, 1'b0);
    bitp(1'b1, 1'b0);
    repeat (4) tick(1'b1);
  endtask

  task automatic exp_frame(input logic [7:0] d, input logic pe, fe, bk, ov);
    frm_t f;
    f.d = d; f.pe = pe; f.fe = fe; f.bk = bk; f.ov = ov;
    exp_q.push_back(f);
  endtask

  task automatic exp_state(input int id, input logic [7:0] d, input logic v, pe, fe, bk, ov,
                           input int nd);
    st_t s;
    s.id = id; s.d = d; s.v = v; s.pe = pe; s.fe = fe; s.bk = bk; s.ov = ov; s.ndone = nd;
    st_q.push_back(s);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx       = 1'b1;
    bus.s_tick   = 1'b0;
    bus.rd_en    = 1'b0;
    bus.par_mode = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_state(0, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (8) tick(1'b1);

    // 8N1 basic frame
    exp_frame(8'hA5, 0, 0, 0, 0);
    send(8'hA5, 0, 1'b0, -1);
    exp_state(1, 8'hA5, 1, 0, 0, 0, 0, 1);
    rd();
    exp_state(2, 8'hA5, 0, 0, 0, 0, 0, 1);

    // Parity: even with wrong bit, even with right bit, odd with right bit
    bus.par_mode = 2'b01;
    exp_frame(8'h03, 1, 0, 0, 0);
    send(8'h03, 1, 1'b1, -1);
    rd();
    exp_state(3, 8'h03, 0, 1, 0, 0, 0, 2);
    exp_frame(8'h03, 0, 0, 0, 0);
    send(8'h03, 1, 1'b0, -1);
    rd();
    bus.par_mode = 2'b10;
    exp_frame(8'h03, 0, 0, 0, 0);
    send(8'h03, 1, 1'b1, -1);
    rd();
    bus.par_mode = 2'b00;
    exp_state(4, 8'h03, 0, 0, 0, 0, 0, 4);

    // False start: 4-tick low glitch
    for (int t = 0; t < 4; t++) tick(1'b0);
    for (int t = 0; t < 24; t++) tick(1'b1);
    exp_state(5, 8'h03, 0, 0, 0, 0, 0, 4);
    exp_frame(8'h3C, 0, 0, 0, 0);
    send(8'h3C, 0, 1'b0, -1);
    rd();

    // Break: line low for three frame times
    exp_frame(8'h00, 0, 1, 1, 0);
    for (int t = 0; t < 480; t++) tick(1'b0);
    exp_state(6, 8'h00, 1, 0, 1, 1, 0, 6);
    for (int t = 0; t < 10; t++) tick(1'b1);
    rd();
    exp_state(7, 8'h00, 0, 0, 1, 1, 0, 6);
    exp_frame(8'h5A, 0, 0, 0, 0);
    send(8'h5A, 0, 1'b0, -1);
    rd();

    // Overrun, with a single-sample glitch on data bit 1 of the second frame
    exp_frame(8'h11, 0, 0, 0, 0);
    send(8'h11, 0, 1'b0, -1);
    exp_frame(8'h22, 0, 0, 0, 1);
    send(8'h22, 0, 1'b0, 1);
    exp_state(8, 8'h22, 1, 0, 0, 0, 1, 9);
    rd();
    exp_state(9, 8'h22, 0, 0, 0, 0, 0, 9);

    // Reset in the middle of DATA with unread data pending
    exp_frame(8'h96, 0, 0, 0, 0);
    send(8'h96, 0, 1'b0, -1);
    bitp(1'b0, 1'b0);
    bitp(1'b1, 1'b0);
    bitp(1'b0, 1'b0);
    for (int t = 0; t < 5; t++) tick(1'b1);
    @(negedge clk);
    reset  = 1'b1;
    bus.rx = 1'b1;
    #1;
    exp_state(10, 8'h00, 0, 0, 0, 0, 0, 10);
    reset = 1'b0;
    for (int t = 0; t < 20; t++) tick(1'b1);
    exp_frame(8'hC3, 0, 0, 0, 0);
    send(8'hC3, 0, 1'b0, -1);
    rd();
    exp_state(11, 8'hC3, 0, 0, 0, 0, 0, 11);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

`default_nettype wire
